aer_rate_encoder: RTL and testbench
===================================

# aer_rate_encoder

Upstream stimulus stage for the FF-STDP SNN core. It holds one input sample of pixel intensities and converts them into deterministic rate-coded spike trains over TIME_STEP time steps. Spikes and end-of-step ticks are emitted as AER events on a 4-phase REQ/ACK handshake that connects directly to the core's AERIN_ADDR / AERIN_REQ / AERIN_ACK input.

## Interface
- INPUT_NEURON, 27: number of pixels / pre-synaptic neurons
- TIME_STEP, 8: time steps per sample
- PIX_WIDTH, 8: pixel intensity width (unsigned)
- AER_WIDTH, 12: AER address width; must be ≥ 2 + $clog2(INPUT_NEURON)
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- PIX_WR_EN  in  1  pixel buffer write strobe
- PIX_WR_ADDR  in  $clog2(INPUT_NEURON)  pixel index
- PIX_WR_DATA  in  PIX_WIDTH  pixel value
- START  in  1  begin encoding the buffered sample (level sampled per cycle)
- AERIN_ADDR  out  AER_WIDTH  event address: [AER_WIDTH-1:AER_WIDTH-2] = type, low bits = neuron index
- AERIN_REQ  out  1  event request
- AERIN_ACK  in  1  event acknowledge from core
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  one-cycle pulse after last tick is fully handshaken

## Operation
- Storage: pix[INPUT_NEURON] (PIX_WIDTH) and acc[INPUT_NEURON] (PIX_WIDTH), both register arrays.
- Writes: PIX_WR_EN writes pix[PIX_WR_ADDR] only in IDLE. Ignored when BUSY. Addresses ≥ INPUT_NEURON are ignored.
- Encoding per neuron i, per step: {carry, acc[i]} = acc[i] + pix[i]. carry = 1 → spike. acc[i] keeps the low PIX_WIDTH bits (wraps).
  - Spike count over the sample = floor(pix*TIME_STEP / 2^PIX_WIDTH).
  - Example: pix = 128 spikes at steps 1, 3, 5, 7.
- acc[] is cleared to 0 when START is accepted. pix[] is never cleared by START.
- Event types:
  - 2'b00: spike; low bits = i
  - 2'b01: time-step tick; low bits = 0
  - Codes 10 and 11 are never emitted.
  - Unused middle bits are 0.
- FSM states: IDLE, SCAN, SEND_REQ, WAIT_ACK_LOW, TICK_REQ, TICK_WAIT, FINISH.
  - IDLE: on START → clear acc, step=0, i=0 → SCAN.
  - SCAN: evaluate/update neuron i in one cycle.
    - Spike → latch addr → SEND_REQ.
    - No spike and i < INPUT_NEURON-1 → i+1.
    - No spike and i = INPUT_NEURON-1 → TICK_REQ.
  - SEND_REQ: REQ=1 until ACK sampled high → WAIT_ACK_LOW (REQ=0).
  - WAIT_ACK_LOW: when ACK sampled low:
    - i < INPUT_NEURON-1 → i+1, SCAN.
    - Otherwise → TICK_REQ.
  - TICK_REQ/TICK_WAIT: same 4-phase handshake with the tick address. On completion:
    - step < TIME_STEP-1 → step+1, i=0, SCAN.
    - Otherwise → FINISH.
  - FINISH: DONE=1 for one cycle → IDLE.
- START while BUSY is ignored.
- Events are emitted in ascending neuron index within a step. Each step ends with exactly one tick.

## Timing
- Reset (RST_N low, any state, mid-handshake included):
  - Outputs: AERIN_REQ=0, AERIN_ADDR=0, BUSY=0, DONE=0.
  - State: FSM=IDLE, acc=0, pix=0, step=0, i=0.
  - Recovery: first edge after RST_N rises already operates.
- START sampled high in IDLE at edge 0: BUSY=1 and SCAN from edge 0. Neuron 0 is evaluated in the cycle after edge 0. If it spikes, REQ=1 after edge 1.
- Handshake:
  - AERIN_ADDR is stable for the whole REQ-high interval.
  - REQ drops the cycle after ACK is seen high. REQ does not rise again until ACK has been seen low.
  - Any ACK latency is tolerated with no timeout.
- Non-spiking neurons cost 1 cycle each.
- Each event with immediate ACK costs ≥ 3 cycles: REQ, ACK-high seen, ACK-low seen.
- BUSY falls in the same cycle that DONE pulses.

## Test plan
- All pix = 0, ACK echoes REQ after 1 cycle → exactly 8 events, all addr 0x400 (type 01); DONE once; BUSY then 0.
- pix[5] = 128, others 0 → per step: a spike addr 0x005 at steps 1, 3, 5, 7 only, then a tick; total 4 spikes + 8 ticks.
- All pix = 255 → 7 spikes per neuron (189 total); step 0 has no spikes; ascending order in each step.
- ACK delayed 6 cycles after REQ, held 3 cycles → REQ stays high with a stable addr until ACK; no new REQ while ACK is high.
- RST_N pulsed low while in SEND_REQ → REQ=0 immediately (async); after release, pix reads 0 and an all-zero run gives ticks only.
- START re-pulsed mid-run, and PIX_WR_EN while BUSY → run is unchanged; buffer contents are unchanged on the next run.

Source files
------------

// File: rtl/aer_rate_encoder.sv
// Rate-codes a buffered pixel sample into AER spike/tick events over TIME_STEP steps.
// Events leave on a 4-phase REQ/ACK handshake; any ACK latency simply stalls the scan.
module aer_rate_encoder #(
   parameter int INPUT_NEURON = 27,
   parameter int TIME_STEP    = 8,
   parameter int PIX_WIDTH    = 8,
   parameter int AER_WIDTH    = 12
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_pix_wr_en,
   input  logic [$clog2(INPUT_NEURON)-1:0] i_pix_wr_addr,
   input  logic [PIX_WIDTH-1:0]            i_pix_wr_data,
   input  logic                            i_start,
   output logic [AER_WIDTH-1:0]            o_aerin_addr,
   output logic                            o_aerin_req,
   input  logic                            i_aerin_ack,
   output logic                            o_busy,
   output logic                            o_done
);

   localparam int IW = $clog2(INPUT_NEURON);
   localparam int SW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(INPUT_NEURON - 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(TIME_STEP - 1);
   localparam logic [AER_WIDTH-1:0] TICK_ADDR = {2'b01, {(AER_WIDTH-2){1'b0}}};

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_SCAN         = 3'd1;
   localparam logic [2:0] ST_SEND_REQ     = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK_LOW = 3'd3;
   localparam logic [2:0] ST_TICK_REQ     = 3'd4;
   localparam logic [2:0] ST_TICK_WAIT    = 3'd5;
   localparam logic [2:0] ST_FINISH       = 3'd6;

   logic [2:0]           r_state;
   logic [PIX_WIDTH-1:0] r_pix [INPUT_NEURON];
   logic [PIX_WIDTH-1:0] r_acc [INPUT_NEURON];
   logic [IW-1:0]        r_idx;
   logic [SW-1:0]        r_step;
   logic [AER_WIDTH-1:0] r_addr;
   logic                 r_req;
   logic                 r_busy;
   logic                 r_done;

   logic [PIX_WIDTH:0]   w_sum;
   logic [AER_WIDTH-1:0] w_spike_addr;
   logic                 w_last_idx;
   logic                 w_last_step;

   // Carry out of the phase accumulator is the spike for this neuron/step.
   assign w_sum        = {1'b0, r_acc[r_idx]} + {1'b0, r_pix[r_idx]};
   assign w_spike_addr = {{(AER_WIDTH-IW){1'b0}}, r_idx};
   assign w_last_idx   = (r_idx == LAST_IDX);
   assign w_last_step  = (r_step == LAST_STEP);

   assign o_aerin_addr = r_addr;
   assign o_aerin_req  = r_req;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < INPUT_NEURON; k++) r_pix[k] <= '0;
      end else if (i_pix_wr_en && r_state == ST_IDLE && i_pix_wr_addr <= LAST_IDX) begin
         r_pix[i_pix_wr_addr] <= i_pix_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         for (int k = 0; k < INPUT_NEURON; k++) r_acc[k] <= '0;
         r_idx  <= '0;
         r_step <= '0;
         r_addr <= '0;
         r_req  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  for (int k = 0; k < INPUT_NEURON; k++) r_acc[k] <= '0;
                  r_idx   <= '0;
                  r_step  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_acc[r_idx] <= w_sum[PIX_WIDTH-1:0];
               if (w_sum[PIX_WIDTH]) begin
                  r_addr  <= w_spike_addr;
                  r_req   <= 1'b1;
                  r_state <= ST_SEND_REQ;
               end else if (w_last_idx) begin
                  r_addr  <= TICK_ADDR;
                  r_req   <= 1'b1;
                  r_state <= ST_TICK_REQ;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_SEND_REQ: begin
               if (i_aerin_ack) begin
                  r_req   <= 1'b0;
                  r_state <= ST_WAIT_ACK_LOW;
               end
            end
            ST_WAIT_ACK_LOW: begin
               if (!i_aerin_ack) begin
                  if (w_last_idx) begin
                     r_addr  <= TICK_ADDR;
                     r_req   <= 1'b1;
                     r_state <= ST_TICK_REQ;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_SCAN;
                  end
               end
            end
            ST_TICK_REQ: begin
               if (i_aerin_ack) begin
                  r_req   <= 1'b0;
                  r_state <= ST_TICK_WAIT;
               end
            end
            ST_TICK_WAIT: begin
               if (!i_aerin_ack) begin
                  if (w_last_step) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_FINISH;
                  end else begin
                     r_step  <= r_step + 1'b1;
                     r_idx   <= '0;
                     r_state <= ST_SCAN;
                  end
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Randomised bench for aer_rate_encoder: event streams are compared against a
// spike-count reference built from floor(pix*(s+1)/256) - floor(pix*s/256).
module tb_aer_rate_encoder;

   localparam int N  = 27;
   localparam int TS = 8;
   localparam logic [11:0] TICK = 12'h400;

   logic        clk;
   logic        rst_n;
   logic        pix_wr_en;
   logic [4:0]  pix_wr_addr;
   logic [7:0]  pix_wr_data;
   logic        start;
   logic [11:0] aer_addr;
   logic        req;
   logic        ack;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   int tb_pix [N];
   logic [11:0] ev_q  [$];
   logic [11:0] exp_q [$];
   int done_cnt  = 0;
   int stab_err  = 0;
   int proto_err = 0;
   int busy_err  = 0;
   int ack_delay = 1;
   int ack_hold  = 1;

   aer_rate_encoder dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pix_wr_en   (pix_wr_en),
      .i_pix_wr_addr (pix_wr_addr),
      .i_pix_wr_data (pix_wr_data),
      .i_start       (start),
      .o_aerin_addr  (aer_addr),
      .o_aerin_req   (req),
      .i_aerin_ack   (ack),
      .o_busy        (busy),
      .o_done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Core-side responder: raise ACK ack_delay cycles after REQ, keep it at least ack_hold cycles.
   initial begin
      int cnt;
      int hcnt;
      cnt  = 0;
      hcnt = 0;
      ack  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!ack && req) begin
            cnt++;
            if (cnt >= ack_delay) begin
               ack  = 1'b1;
               cnt  = 0;
               hcnt = 0;
            end
         end else if (ack) begin
            hcnt++;
            if (!req && hcnt >= ack_hold) ack = 1'b0;
         end else begin
            cnt = 0;
         end
      end
   end

   // Event logger and handshake watchdog.
   initial begin
      logic        prev_req;
      logic        prev_ack;
      logic [11:0] prev_addr;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (req && !prev_req) begin
            ev_q.push_back(aer_addr);
            if (prev_ack) proto_err++;
         end
         if (req && prev_req && aer_addr !== prev_addr) stab_err++;
         if (done) begin
            done_cnt++;
            if (busy) busy_err++;
         end
         prev_req  = req;
         prev_ack  = ack;
         prev_addr = aer_addr;
      end
   end

   task automatic write_pix(input int idx, input int val);
      pix_wr_en   = 1'b1;
      pix_wr_addr = 5'(idx);
      pix_wr_data = 8'(val);
      @(posedge clk);
      #1;
      pix_wr_en = 1'b0;
      if (idx < N) tb_pix[idx] = val & 255;
   endtask

   task automatic load_all(input int mode, input int val);
      for (int i = 0; i < N; i++)
         write_pix(i, (mode == 0) ? val : int'($urandom_range(0, 255)));
   endtask

   function automatic void build_exp();
      exp_q.delete();
      for (int s = 0; s < TS; s++) begin
         for (int i = 0; i < N; i++)
            if ((tb_pix[i] * (s + 1)) / 256 > (tb_pix[i] * s) / 256)
               exp_q.push_back(12'(i));
         exp_q.push_back(TICK);
      end
   endfunction

   function automatic int first_diff();
      int m;
      m = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
      for (int k = 0; k < m; k++)
         if (ev_q[k] !== exp_q[k]) return k;
      if (ev_q.size() != exp_q.size()) return m;
      return -1;
   endfunction

   function automatic int spike_count();
      int c;
      c = 0;
      foreach (ev_q[k]) if (ev_q[k][11:10] == 2'b00) c++;
      return c;
   endfunction

   task automatic run_sample(input bit disturb, output bit timed_out);
      int n;
      ev_q.delete();
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 20000) begin
         if (disturb && busy) begin
            start       = 1'($urandom_range(0, 1));
            pix_wr_en   = 1'($urandom_range(0, 1));
            pix_wr_addr = 5'($urandom_range(0, N - 1));
            pix_wr_data = 8'($urandom);
         end else begin
            start     = 1'b0;
            pix_wr_en = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start     = 1'b0;
      pix_wr_en = 1'b0;
      timed_out = !done;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
      checks++; if (aer_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h want=000", aer_addr); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) tb_pix[i] = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      int n;
      ev_q.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL latency_busy got=%b want=1", busy); end
      n = 0;
      while (!req && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (n != N) begin failures++; $display("FAIL latency_first_req got=%0d want=%0d", n, N); end
      checks++; if (aer_addr !== TICK) begin failures++; $display("FAIL latency_addr got=%h want=%h", aer_addr, TICK); end
      n = 0;
      while (!done && n < 20000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (!done) begin failures++; $display("FAIL latency_timeout got=%0d want=done", n); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_all_zero();
      bit to;
      int d;
      load_all(0, 0);
      build_exp();
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to) begin failures++; $display("FAIL zero_timeout got=1 want=0"); end
      checks++; if (d != -1) begin failures++; $display("FAIL zero_events idx=%0d got_n=%0d want_n=%0d", d, ev_q.size(), exp_q.size()); end
      checks++; if (ev_q.size() != 8) begin failures++; $display("FAIL zero_count got=%0d want=8", ev_q.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d want=1", done_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_single();
      bit to;
      int d;
      write_pix(5, 128);
      build_exp();
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to) begin failures++; $display("FAIL single_timeout got=1 want=0"); end
      checks++; if (d != -1) begin failures++; $display("FAIL single_events idx=%0d got=%h want=%h", d, (d < ev_q.size()) ? ev_q[d] : 12'hfff, (d < exp_q.size()) ? exp_q[d] : 12'hfff); end
      checks++; if (spike_count() != 4) begin failures++; $display("FAIL single_spikes got=%0d want=4", spike_count()); end
      checks++; if (ev_q.size() != 12) begin failures++; $display("FAIL single_total got=%0d want=12", ev_q.size()); end
   endtask

   task automatic test_all_max();
      bit to;
      int d;
      load_all(0, 255);
      build_exp();
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to) begin failures++; $display("FAIL max_timeout got=1 want=0"); end
      checks++; if (d != -1) begin failures++; $display("FAIL max_events idx=%0d got_n=%0d want_n=%0d", d, ev_q.size(), exp_q.size()); end
      checks++; if (spike_count() != 189) begin failures++; $display("FAIL max_spikes got=%0d want=189", spike_count()); end
      checks++; if (ev_q.size() == 0 || ev_q[0] !== TICK) begin failures++; $display("FAIL max_step0_no_spike got=%h want=%h", (ev_q.size() > 0) ? ev_q[0] : 12'hfff, TICK); end
   endtask

   task automatic test_slow_ack();
      bit to;
      int d;
      ack_delay = 6;
      ack_hold  = 3;
      stab_err  = 0;
      proto_err = 0;
      load_all(1, 0);
      build_exp();
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to) begin failures++; $display("FAIL slow_timeout got=1 want=0"); end
      checks++; if (d != -1) begin failures++; $display("FAIL slow_events idx=%0d got_n=%0d want_n=%0d", d, ev_q.size(), exp_q.size()); end
      checks++; if (stab_err != 0) begin failures++; $display("FAIL slow_addr_stable got=%0d want=0", stab_err); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL slow_req_while_ack got=%0d want=0", proto_err); end
      ack_delay = 1;
      ack_hold  = 1;
   endtask

   task automatic test_random();
      bit to;
      int d;
      for (int it = 0; it < 4; it++) begin
         ack_delay = $urandom_range(1, 4);
         ack_hold  = $urandom_range(1, 3);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0) write_pix(i, $urandom_range(0, 255));
         build_exp();
         run_sample(1'b0, to);
         d = first_diff();
         checks++; if (to || d != -1) begin failures++; $display("FAIL random_run%0d idx=%0d to=%0d got_n=%0d want_n=%0d", it, d, to, ev_q.size(), exp_q.size()); end
      end
      ack_delay = 1;
      ack_hold  = 1;
   endtask

   task automatic test_busy_ignore();
      bit to;
      int d;
      load_all(1, 0);
      build_exp();
      run_sample(1'b1, to);
      d = first_diff();
      checks++; if (to || d != -1) begin failures++; $display("FAIL busy_disturbed_run idx=%0d to=%0d got_n=%0d want_n=%0d", d, to, ev_q.size(), exp_q.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_done_count got=%0d want=1", done_cnt); end
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to || d != -1) begin failures++; $display("FAIL busy_buffer_kept idx=%0d to=%0d got_n=%0d want_n=%0d", d, to, ev_q.size(), exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit to;
      int d;
      int n;
      ack_delay = 6;
      ack_hold  = 2;
      load_all(0, 200);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (!(req && aer_addr[11:10] == 2'b00) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++; if (n >= 5000) begin failures++; $display("FAIL midrst_reach_send_req got=timeout want=spike_req"); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL midrst_req_async got=%b want=0", req); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) tb_pix[i] = 0;
      ack_delay = 1;
      ack_hold  = 1;
      repeat (10) @(posedge clk);
      #1;
      build_exp();
      run_sample(1'b0, to);
      d = first_diff();
      checks++; if (to || d != -1) begin failures++; $display("FAIL midrst_ticks_only idx=%0d to=%0d got_n=%0d want_n=%0d", d, to, ev_q.size(), exp_q.size()); end
      checks++; if (spike_count() != 0) begin failures++; $display("FAIL midrst_pix_cleared got=%0d want=0", spike_count()); end
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      pix_wr_en   = 1'b0;
      pix_wr_addr = '0;
      pix_wr_data = '0;
      test_reset();
      test_latency();
      test_all_zero();
      test_single();
      test_all_max();
      test_slow_ack();
      test_random();
      test_busy_ignore();
      test_reset_mid();
      checks++; if (busy_err != 0) begin failures++; $display("FAIL done_with_busy got=%0d want=0", busy_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
